// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - sequential 8x8 shift-add multiplier / restoring divider (MUL AB / DIV AB)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request pulse, accepted only in IDLE or DONE
//   op       in   0 = MUL AB, 1 = DIV AB
//   a_data   in   [7:0] ACC operand (multiplicand / dividend)
//   b_data   in   [7:0] B operand (multiplier / divisor)
//   psw_in   in   [7:0] PSW at request time
//   busy     out  high while iterating (state RUN)
//   done     out  one-cycle completion pulse (state DONE)
//   a_out    out  [7:0] product low byte / quotient
//   b_out    out  [7:0] product high byte / remainder
//   psw_out  out  [7:0] PSW with CY (bit 7) cleared and OV (bit 2) updated
//
// Optional feature: MULDIV_DIV0_FAST_EN - DIV by zero bypasses RUN and completes immediately.
module mul_div_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a_data,
    input  logic [7:0] b_data,
    input  logic [7:0] psw_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [7:0] psw_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       op_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] psw_r;
    // hi: partial product high byte / partial remainder
    // lo: multiplier shifting out LSB-first / dividend shifting out MSB-first, quotient shifting in
    logic [7:0] hi;
    logic [7:0] lo;

    logic       accept;
    logic       last_iter;
    logic [8:0] mul_sum;
    logic [8:0] div_shift;
    logic [8:0] div_diff;
    logic       div_ge;
    logic [7:0] hi_step;
    logic [7:0] lo_step;
    logic [7:0] res_a;
    logic [7:0] res_b;
    logic       res_ov;
    logic [7:0] res_psw;

    assign accept    = start && (state != RUN);
    assign last_iter = (cnt == 4'd7);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

`ifdef MULDIV_DIV0_FAST_EN
    logic div0_in;
    assign div0_in = op && (b_data == 8'h00);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef MULDIV_DIV0_FAST_EN
                    state_next = div0_in ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration of either algorithm, computed from the current hi/lo.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : 9'd0);
        div_shift = {hi, lo[7]};
        div_diff  = div_shift - {1'b0, b_r};
        div_ge    = (div_shift >= {1'b0, b_r});
        if (op_r) begin
            hi_step = div_ge ? div_diff[7:0] : div_shift[7:0];
            lo_step = {lo[6:0], div_ge};
        end else begin
            // Right shift of {carry, sum, multiplier}: the finished product bit drops into lo.
            hi_step = mul_sum[8:1];
            lo_step = {mul_sum[0], lo[7:1]};
        end
    end

    // Final results taken from the last iteration's step values.
    always_comb begin
        res_a  = lo_step;
        res_b  = hi_step;
        res_ov = 1'b0;
        if (op_r) begin
            if (b_r == 8'h00) begin
                res_a  = 8'hFF;
                res_b  = a_r;
                res_ov = 1'b1;
            end
        end else begin
            res_ov = (hi_step != 8'h00);
        end
        res_psw = (psw_r & 8'h7B) | {5'b00000, res_ov, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_r    <= 1'b0;
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            psw_r   <= 8'h00;
            hi      <= 8'h00;
            lo      <= 8'h00;
            a_out   <= 8'h00;
            b_out   <= 8'h00;
            psw_out <= 8'h00;
        end else begin
            state <= state_next;
            if (accept) begin
                op_r  <= op;
                a_r   <= a_data;
                b_r   <= b_data;
                psw_r <= psw_in;
                cnt   <= 4'd0;
                hi    <= 8'h00;
                lo    <= op ? a_data : b_data;
`ifdef MULDIV_DIV0_FAST_EN
                if (div0_in) begin
                    a_out   <= 8'hFF;
                    b_out   <= a_data;
                    psw_out <= (psw_in & 8'h7B) | 8'h04;
                end
`endif
            end else if (state == RUN) begin
                hi  <= hi_step;
                lo  <= lo_step;
                cnt <= last_iter ? 4'd0 : cnt + 4'd1;
                if (last_iter) begin
                    a_out   <= res_a;
                    b_out   <= res_b;
                    psw_out <= res_psw;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb/tb_mul_div_seq.sv - directed self-checking bench for mul_div_seq
module tb_mul_div_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] a_data;
    logic [7:0] b_data;
    logic [7:0] psw_in;
    logic       busy;
    logic       done;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [7:0] psw_out;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_DIV0_FAST_EN
    localparam int DIV0_LAT = 0;
`else
    localparam int DIV0_LAT = 8;
`endif

    mul_div_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a_data  (a_data),
        .b_data  (b_data),
        .psw_in  (psw_in),
        .busy    (busy),
        .done    (done),
        .a_out   (a_out),
        .b_out   (b_out),
        .psw_out (psw_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request, lets it be accepted at the next edge, then scrambles the inputs.
    task automatic start_op(input logic o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
        start  = 1'b1;
        op     = o;
        a_data = a;
        b_data = b;
        psw_in = p;
        tick();
        start  = 1'b0;
        op     = ~o;
        a_data = 8'($urandom);
        b_data = 8'($urandom);
        psw_in = 8'($urandom);
    endtask

    // Counts edges after acceptance until done; also counts busy cycles seen.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
        check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ep);
        check({tag, "_a_out"}, {8'h00, a_out}, {8'h00, ea});
        check({tag, "_b_out"}, {8'h00, b_out}, {8'h00, eb});
        check({tag, "_psw_out"}, {8'h00, psw_out}, {8'h00, ep});
    endtask

    initial begin
        int seen_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        a_data = 8'h00;
        b_data = 8'h00;
        psw_in = 8'h00;
        tick();
        tick();
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check_res("reset", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        tick();

        // MUL 0x50 * 0xA0 = 0x3200, OV set, CY cleared
        start_op(1'b0, 8'h50, 8'hA0, 8'h80);
        check("mul1_busy_after_accept", {15'd0, busy}, 16'd1);
        wait_done("mul1", 8);
        check_res("mul1", 8'h00, 8'h32, 8'h04);
        tick();
        check("mul1_done_pulse_width", {15'd0, done}, 16'd0);
        tick();
        check_res("mul1_hold", 8'h00, 8'h32, 8'h04);

        // MUL 0x0C * 0x0B = 0x0084, OV clear
        start_op(1'b0, 8'h0C, 8'h0B, 8'h00);
        wait_done("mul2", 8);
        check_res("mul2", 8'h84, 8'h00, 8'h00);
        tick();

        // DIV 0xFB / 0x12 = 13 rem 17
        start_op(1'b1, 8'hFB, 8'h12, 8'h84);
        wait_done("div1", 8);
        check_res("div1", 8'h0D, 8'h11, 8'h00);
        tick();

        // DIV by zero
        start_op(1'b1, 8'h37, 8'h00, 8'hC4);
        wait_done("div0", DIV0_LAT);
        check_res("div0", 8'hFF, 8'h37, 8'h44);
        tick();
        tick();

        // Reset mid-run: accept at edge N, stray start at N+3, reset at N+4
        start_op(1'b0, 8'h12, 8'h34, 8'hFF);   // edge N
        tick();                                 // edge N+1
        tick();                                 // edge N+2
        start = 1'b1;
        op    = 1'b1;
        tick();                                 // edge N+3: ignored while running
        start = 1'b0;
        check("run_ignores_start_busy", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        tick();                                 // edge N+4: reset
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check_res("abort", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen_done++;
        end
        check("abort_no_done_or_busy", 16'(seen_done), 16'd0);

        // start coincident with reset is ignored
        rst_n  = 1'b0;
        start  = 1'b1;
        op     = 1'b0;
        a_data = 8'h03;
        b_data = 8'h05;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("start_in_reset_busy", {15'd0, busy}, 16'd0);
        check_res("start_in_reset", 8'h00, 8'h00, 8'h00);

        // Back-to-back: MUL 0xFF*0xFF, then DIV 0xFF/0x10 issued in the DONE cycle
        start_op(1'b0, 8'hFF, 8'hFF, 8'h00);
        wait_done("b2b_mul", 8);
        check_res("b2b_mul", 8'h01, 8'hFE, 8'h04);
        start_op(1'b1, 8'hFF, 8'h10, 8'h00);
        check("b2b_no_gap_busy", {15'd0, busy}, 16'd1);
        check("b2b_no_gap_done", {15'd0, done}, 16'd0);
        check_res("b2b_hold_during_run", 8'h01, 8'hFE, 8'h04);
        wait_done("b2b_div", 8);
        check_res("b2b_div", 8'h0F, 8'h0F, 8'h00);
        tick();
        check("b2b_back_to_idle", {14'd0, busy, done}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL provide one clock and a synchronous, active-low reset: clk (rising edge) and rst_n (synchronous, active-low).
REQ-002 SHALL have port: clk  input  1  system clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request pulse; sampled when idle or done.
REQ-005 SHALL have port: op  input  1  0 = MUL AB, 1 = DIV AB.
REQ-006 SHALL have port: a_data  input  8  ACC operand (multiplicand/dividend).
REQ-007 SHALL have port: b_data  input  8  B operand (multiplier/divisor).
REQ-008 SHALL have port: psw_in  input  8  PSW at request time.
REQ-009 SHALL have port: busy  output  1  high while iterating.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: a_out  output  8  new ACC (product low byte / quotient).
REQ-012 SHALL have port: b_out  output  8  new B (product high byte / remainder).
REQ-013 SHALL have port: psw_out  output  8  PSW with CY (bit 7) and OV (bit 2) updated.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-015 SHALL accept start only in IDLE or DONE, capturing op, a_data, b_data and psw_in on that edge; later input changes SHALL be ignored.
REQ-016 SHALL ignore start while in RUN; no queuing.
REQ-017 SHALL, on acceptance at edge N, occupy RUN for cycles N+1..N+8 (4-bit iteration counter, 0..7), then DONE for cycle N+9, then IDLE unless start accepted.
REQ-018 MUL SHALL be shift-add, one multiplier bit per RUN cycle; 16-bit product: b_out = [15:8], a_out = [7:0].
REQ-019 MUL SHALL set OV=1 if product > 8'hFF, else OV=0.
REQ-020 DIV SHALL be restoring division, one quotient bit per RUN cycle, MSB first; a_out = quotient, b_out = remainder, OV=0.
REQ-021 DIV with b_data==0 SHALL yield a_out=8'hFF, b_out=captured a_data, OV=1.
REQ-022 CY (psw_out[7]) SHALL be cleared for every operation; all other psw_out bits SHALL equal captured psw_in.
REQ-023 a_out, b_out and psw_out SHALL update on entry to DONE and hold until the next accepted start completes.
REQ-024 start accepted in the DONE cycle SHALL enter RUN on the next edge (back-to-back, no idle gap).

Reset
REQ-025 rst_n low at a clock edge SHALL force IDLE, counter 0, busy=0, done=0, a_out=0, b_out=0, psw_out=0, regardless of state.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-027 start sampled in the same edge as rst_n low SHALL be ignored.

Configuration
REQ-028 Macro MULDIV_DIV0_FAST_EN defined: DIV with b_data==0 SHALL skip RUN, go IDLE->DONE, done at N+1.
REQ-029 Macro MULDIV_DIV0_FAST_EN undefined: DIV by zero SHALL take full 8 RUN cycles, done at N+9; results per REQ-021 either way.

Verification
REQ-030 MUL a=8'h50 b=8'hA0 psw_in=8'h80 -> done at N+9, a_out=8'h00, b_out=8'h32, psw_out=8'h04.
REQ-031 MUL a=8'h0C b=8'h0B psw_in=8'h00 -> a_out=8'h84, b_out=8'h00, psw_out=8'h00.
REQ-032 DIV a=8'hFB b=8'h12 psw_in=8'h84 -> a_out=8'h0D, b_out=8'h11, psw_out=8'h00.
REQ-033 DIV a=8'h37 b=8'h00 psw_in=8'hC4 -> a_out=8'hFF, b_out=8'h37, psw_out=8'h44; done at N+1 with MULDIV_DIV0_FAST_EN, N+9 without.
REQ-034 MUL started, rst_n low at N+4 -> next edge busy=0, outputs 0, no done; start pulsed at N+3 ignored.
REQ-035 start re-asserted in DONE cycle (MUL 8'hFF*8'hFF then DIV 8'hFF/8'h10) -> first a_out=8'h01, b_out=8'hFE, OV=1; second done 9 cycles later, a_out=8'h0F, b_out=8'h0F, OV=0.
